// File: rtl/disp_axi_pkg.sv
// Shared types and constants for the display AXI4 read path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: owner id type, arbiter state encoding, fixed burst shape constants
// that the display top level uses to tie off ARLEN/ARSIZE/ARBURST.
package disp_axi_pkg;

   // Which requester owns an issued burst.
   typedef enum logic {
      OWN_DISP = 1'b0,   // frame-buffer fetch, priority requester
      OWN_AUX  = 1'b1    // secondary fetch (overlay / cursor)
   } owner_t;

   // AR-side arbiter state, kept as plain constants so it drops into older code.
   typedef logic [0:0] arb_state_t;
   localparam arb_state_t IDLE  = 1'b0;
   localparam arb_state_t ISSUE = 1'b1;

   // Every burst is 16 beats of 64 bits, INCR.
   localparam int         BURST_BEATS = 16;
   localparam logic [7:0] AXI_ARLEN   = 8'(BURST_BEATS - 1);
   localparam logic [2:0] AXI_ARSIZE  = 3'b011;
   localparam logic [1:0] AXI_ARBURST = 2'b01;

endpackage

// File: rtl/disp_owner_fifo.sv
// Owner-id FIFO: remembers which requester owns each burst issued on AR, in issue order.
// Latency: push visible at head the cycle after the write when empty; head is combinational.
// Backpressure: push ignored when full, pop ignored when empty (caller guarantees neither).
// Ports: clk_i / rst_ni (async active-low), push_i + push_dat_i, pop_i,
//        head_dat_o (oldest entry), empty_o, full_o, count_o (entries held).
module disp_owner_fifo #(
   parameter int DEPTH = 4   // power of two so pointers wrap naturally
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     push_dat_i,
   input  logic                     pop_i,
   output logic                     head_dat_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int           AW       = $clog2(DEPTH);
   localparam logic [AW:0]  FULL_CNT = DEPTH[AW:0];

   logic [DEPTH-1:0] mem_q, mem_d;
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      cnt_q;
   logic             push_ok, pop_ok;

   assign empty_o    = (cnt_q == '0);
   assign full_o     = (cnt_q == FULL_CNT);
   assign push_ok    = push_i & ~full_o;
   assign pop_ok     = pop_i & ~empty_o;
   assign head_dat_o = mem_q[rd_ptr_q];
   assign count_o    = cnt_q;

   always_comb begin
      mem_d = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_dat_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q <= mem_d;
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         // Simultaneous push and pop leave the count unchanged.
         if (push_ok && !pop_ok) begin
            cnt_q <= cnt_q + 1'b1;
         end else if (pop_ok && !push_ok) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/disp_rd_arbiter.sv
// Shares one AXI4 AR/R channel between the frame-buffer fetch (R0, priority) and an aux fetch (R1).
// Latency: REQ to ARVALID 1 cycle, AR issues at most every 2 cycles; R path is combinational.
// Backpressure: AR held until ARREADY; RREADY follows the head owner's RREADY; AR stalls at MAX_OUTS.
// Ports: Rk_REQ/Rk_ADDR in, Rk_ACK out (one-cycle AR handshake strobe), Rk_RVALID out / Rk_RREADY in,
//        shared R_DATA/R_LAST, M_AXI_AR*/R* master side, OUTS_CNT (bursts in flight), R_ERR (sticky).
module disp_rd_arbiter
   import disp_axi_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 64,
   parameter int MAX_OUTS           = 4,   // power of two, 2..8
   parameter int STARVE_LIMIT       = 4    // >= 1
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic                            R0_REQ,
   input  logic                            R1_REQ,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   R0_ADDR,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   R1_ADDR,
   output logic                            R0_ACK,
   output logic                            R1_ACK,
   output logic                            R0_RVALID,
   output logic                            R1_RVALID,
   input  logic                            R0_RREADY,
   input  logic                            R1_RREADY,
   output logic                            R_LAST,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   R_DATA,
   output logic                            M_AXI_ARVALID,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   input  logic                            M_AXI_ARREADY,
   input  logic                            M_AXI_RVALID,
   input  logic                            M_AXI_RLAST,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   output logic                            M_AXI_RREADY,
   output logic [$clog2(MAX_OUTS):0]       OUTS_CNT,
   output logic                            R_ERR
);

   localparam int           SW        = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = STARVE_LIMIT[SW-1:0];

   arb_state_t                    state_q, state_d;
   owner_t                        owner_q, owner_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic                          arvalid_q, arvalid_d;
   logic [SW-1:0]                 starve_q, starve_d;
   logic                          r_err_q, r_err_d;

   logic   grant_aux;
   logic   ar_hs;
   logic   fifo_head, fifo_empty, fifo_full, fifo_pop;
   owner_t head_own;
   logic   head_rdy;

   // R1 wins when R0 is idle, or when R0 has already taken STARVE_LIMIT grants in a row.
   assign grant_aux = R1_REQ & (~R0_REQ | (starve_q == STARVE_MAX));
   assign ar_hs     = arvalid_q & M_AXI_ARREADY;

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      araddr_d  = araddr_q;
      arvalid_d = arvalid_q;
      starve_d  = starve_q;
      case (state_q)
         IDLE: begin
            // Full FIFO is the same as OUTS_CNT == MAX_OUTS.
            if ((R0_REQ | R1_REQ) & ~fifo_full) begin
               state_d   = ISSUE;
               arvalid_d = 1'b1;
               if (grant_aux) begin
                  owner_d  = OWN_AUX;
                  araddr_d = R1_ADDR;
                  starve_d = '0;
               end else begin
                  owner_d  = OWN_DISP;
                  araddr_d = R0_ADDR;
                  if (!R1_REQ) begin
                     starve_d = '0;
                  end else if (starve_q != STARVE_MAX) begin
                     starve_d = starve_q + 1'b1;
                  end
               end
            end
         end
         ISSUE: begin
            if (M_AXI_ARREADY) begin
               state_d   = IDLE;
               arvalid_d = 1'b0;
            end
         end
         default: begin
            state_d   = IDLE;
            arvalid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q   <= IDLE;
         owner_q   <= OWN_DISP;
         araddr_q  <= '0;
         arvalid_q <= 1'b0;
         starve_q  <= '0;
         r_err_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         araddr_q  <= araddr_d;
         arvalid_q <= arvalid_d;
         starve_q  <= starve_d;
         r_err_q   <= r_err_d;
      end
   end

   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_ARADDR  = araddr_q;
   assign R0_ACK        = ar_hs & (owner_q == OWN_DISP);
   assign R1_ACK        = ar_hs & (owner_q == OWN_AUX);

   disp_owner_fifo #(
      .DEPTH (MAX_OUTS)
   ) u_owner_fifo (
      .clk_i      (ACLK),
      .rst_ni     (ARESETN),
      .push_i     (ar_hs),
      .push_dat_i (owner_q),
      .pop_i      (fifo_pop),
      .head_dat_o (fifo_head),
      .empty_o    (fifo_empty),
      .full_o     (fifo_full),
      .count_o    (OUTS_CNT)
   );

   // R steering: the oldest outstanding burst owns every beat until its RLAST is accepted.
   assign head_own     = owner_t'(fifo_head);
   assign head_rdy     = (head_own == OWN_AUX) ? R1_RREADY : R0_RREADY;
   assign M_AXI_RREADY = ~fifo_empty & head_rdy;
   assign R0_RVALID    = M_AXI_RVALID & ~fifo_empty & (head_own == OWN_DISP);
   assign R1_RVALID    = M_AXI_RVALID & ~fifo_empty & (head_own == OWN_AUX);
   assign fifo_pop     = M_AXI_RVALID & M_AXI_RREADY & M_AXI_RLAST;
   assign R_DATA       = M_AXI_RDATA;
   assign R_LAST       = M_AXI_RLAST;

   // A beat with nothing outstanding means the slave and this block disagree; latch it.
   assign r_err_d = r_err_q | (M_AXI_RVALID & fifo_empty);
   assign R_ERR   = r_err_q;

endmodule

// File: tb/tb_disp_rd_arbiter.sv
// Directed bench for disp_rd_arbiter: grant order / starvation, AR stall, outstanding limit,
// in-order R steering with per-requester stall, orphan-beat error and async reset.
module tb_disp_rd_arbiter;

   logic        ACLK          = 1'b0;
   logic        ARESETN       = 1'b0;
   logic        R0_REQ        = 1'b0;
   logic        R1_REQ        = 1'b0;
   logic [31:0] R0_ADDR       = '0;
   logic [31:0] R1_ADDR       = '0;
   logic        R0_RREADY     = 1'b0;
   logic        R1_RREADY     = 1'b0;
   logic        M_AXI_ARREADY = 1'b0;
   logic        R0_ACK, R1_ACK, R0_RVALID, R1_RVALID, R_LAST, M_AXI_ARVALID, M_AXI_RREADY, R_ERR;
   logic [63:0] R_DATA;
   logic [31:0] M_AXI_ARADDR;
   logic [2:0]  OUTS_CNT;

   // Slave model: returns 16-beat bursts in AR order while allow_lim permits.
   logic force_rv  = 1'b0;
   int   allow_lim = 0;
   int   ar_cnt    = 0;
   int   done_cnt  = 0;
   int   beat_cnt  = 0;
   wire        mdl_rv       = (ar_cnt > done_cnt) && (done_cnt < allow_lim);
   wire        M_AXI_RVALID = force_rv | mdl_rv;
   wire        M_AXI_RLAST  = mdl_rv && (beat_cnt == 15);
   wire [63:0] M_AXI_RDATA  = {32'h0, 16'(done_cnt), 16'(beat_cnt)};

   int   checks = 0;
   int   errors = 0;

   logic [32:0] rx_q[$];
   logic        ack_log[$];
   int          ack_dbl  = 0;
   logic        prev_ack = 1'b0;

   disp_rd_arbiter #(
      .C_M_AXI_ADDR_WIDTH (32),
      .C_M_AXI_DATA_WIDTH (64),
      .MAX_OUTS           (4),
      .STARVE_LIMIT       (4)
   ) dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .R0_REQ        (R0_REQ),
      .R1_REQ        (R1_REQ),
      .R0_ADDR       (R0_ADDR),
      .R1_ADDR       (R1_ADDR),
      .R0_ACK        (R0_ACK),
      .R1_ACK        (R1_ACK),
      .R0_RVALID     (R0_RVALID),
      .R1_RVALID     (R1_RVALID),
      .R0_RREADY     (R0_RREADY),
      .R1_RREADY     (R1_RREADY),
      .R_LAST        (R_LAST),
      .R_DATA        (R_DATA),
      .M_AXI_ARVALID (M_AXI_ARVALID),
      .M_AXI_ARADDR  (M_AXI_ARADDR),
      .M_AXI_ARREADY (M_AXI_ARREADY),
      .M_AXI_RVALID  (M_AXI_RVALID),
      .M_AXI_RLAST   (M_AXI_RLAST),
      .M_AXI_RDATA   (M_AXI_RDATA),
      .M_AXI_RREADY  (M_AXI_RREADY),
      .OUTS_CNT      (OUTS_CNT),
      .R_ERR         (R_ERR)
   );

   always #5 ACLK = ~ACLK;

   // Monitor: sample handshakes at the edge, update model state 1 time unit later.
   logic        s_rst, s_ar, s_r, s_last, s_v0, s_v1, s_a0, s_a1;
   logic [31:0] s_dat;
   always @(posedge ACLK) begin
      s_rst  = ARESETN;
      s_ar   = M_AXI_ARVALID && M_AXI_ARREADY;
      s_r    = M_AXI_RVALID && M_AXI_RREADY;
      s_last = M_AXI_RLAST;
      s_v0   = R0_RVALID && R0_RREADY;
      s_v1   = R1_RVALID && R1_RREADY;
      s_a0   = R0_ACK;
      s_a1   = R1_ACK;
      s_dat  = R_DATA[31:0];
      #1;
      if (!s_rst) begin
         ar_cnt   = 0;
         done_cnt = 0;
         beat_cnt = 0;
         prev_ack = 1'b0;
      end else begin
         if (s_ar) ar_cnt++;
         if (s_r) begin
            if (s_last) begin
               done_cnt++;
               beat_cnt = 0;
            end else begin
               beat_cnt++;
            end
         end
         if (s_v0) rx_q.push_back({1'b0, s_dat});
         if (s_v1) rx_q.push_back({1'b1, s_dat});
         if (s_a0 || s_a1) begin
            ack_log.push_back(s_a1);
            if (prev_ack || (s_a0 && s_a1)) ack_dbl++;
         end
         prev_ack = s_a0 || s_a1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rst_pulse();
      ARESETN = 1'b0;
      @(negedge ACLK);
      @(negedge ACLK);
      ARESETN = 1'b1;
   endtask

   // Raise REQ at a negedge, wait for ACK, drop REQ after the handshake edge.
   task automatic issue_one(input int k, input logic [31:0] a, input string tag);
      logic got;
      got = 1'b0;
      if (k == 0) begin R0_REQ = 1'b1; R0_ADDR = a; end
      else        begin R1_REQ = 1'b1; R1_ADDR = a; end
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge ACLK);
         if ((k == 0) ? R0_ACK : R1_ACK) got = 1'b1;
      end
      chk(tag, got, 1);
      @(negedge ACLK);
      R0_REQ = 1'b0;
      R1_REQ = 1'b0;
   endtask

   initial begin
      int   base;
      logic [32:0] obs33;
      logic        obs1;

      // Reset values, no clock edge needed.
      #3;
      chk("rst_arvalid", M_AXI_ARVALID, 0);
      chk("rst_araddr",  M_AXI_ARADDR, 0);
      chk("rst_ack",     {R0_ACK, R1_ACK}, 0);
      chk("rst_rvalid",  {R0_RVALID, R1_RVALID}, 0);
      chk("rst_rready",  M_AXI_RREADY, 0);
      chk("rst_outs",    OUTS_CNT, 0);
      chk("rst_rerr",    R_ERR, 0);
      @(negedge ACLK);
      @(negedge ACLK);
      ARESETN = 1'b1;

      // AR stall: ARREADY low for 5 cycles.
      @(negedge ACLK);
      R0_ADDR = 32'h0000_1000;
      R0_REQ  = 1'b1;
      #1;
      chk("stall_arv_pre", M_AXI_ARVALID, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge ACLK);
         chk($sformatf("stall_arv%0d", i), M_AXI_ARVALID, 1);
         chk($sformatf("stall_addr%0d", i), M_AXI_ARADDR, 32'h0000_1000);
         chk($sformatf("stall_ack%0d", i), R0_ACK, 0);
      end
      M_AXI_ARREADY = 1'b1;
      #1;
      chk("stall_ack_hs", {R0_ACK, R1_ACK}, 2'b10);
      @(negedge ACLK);
      chk("stall_ack_gone", R0_ACK, 0);
      chk("stall_arv_gone", M_AXI_ARVALID, 0);
      chk("stall_outs", OUTS_CNT, 1);
      R0_REQ = 1'b0;
      @(negedge ACLK);
      chk("stall_no_regrant", M_AXI_ARVALID, 0);
      rst_pulse();

      // Grant order with both requesters held, starvation limit 4.
      allow_lim = 1000;
      R0_RREADY = 1'b1;
      R1_RREADY = 1'b1;
      base = ack_log.size();
      R0_REQ = 1'b1;
      R1_REQ = 1'b1;
      for (int i = 0; i < 2000 && (ack_log.size() - base) < 10; i++) @(negedge ACLK);
      R0_REQ = 1'b0;
      R1_REQ = 1'b0;
      chk("grant_count", ack_log.size() - base, 10);
      for (int i = 0; i < 10; i++) begin
         obs1 = (base + i < ack_log.size()) ? ack_log[base + i] : 1'bx;
         chk($sformatf("grant_order%0d", i), obs1, (i == 4 || i == 9) ? 1 : 0);
      end
      chk("ack_one_cycle", ack_dbl, 0);
      for (int i = 0; i < 1000 && OUTS_CNT != 0; i++) @(negedge ACLK);
      chk("grant_drain", OUTS_CNT, 0);
      chk("grant_bursts", done_cnt, 10);
      allow_lim = 0;
      rst_pulse();

      // Routing: owners 0,1,0, bursts back to back, R1 stalled 3 cycles.
      R0_RREADY = 1'b1;
      R1_RREADY = 1'b0;
      issue_one(0, 32'h0000_1000, "iss_a");
      issue_one(1, 32'h0000_2000, "iss_b");
      issue_one(0, 32'h0000_3000, "iss_c");
      chk("route_outs3", OUTS_CNT, 3);
      base = rx_q.size();
      allow_lim = 3;
      #1;
      chk("route_b1_rready", M_AXI_RREADY, 1);
      chk("route_b1_r0v", {R0_RVALID, R1_RVALID}, 2'b10);
      for (int i = 0; i < 100 && done_cnt < 1; i++) @(negedge ACLK);
      for (int s = 0; s < 3; s++) begin
         chk($sformatf("route_stall_rready%0d", s), M_AXI_RREADY, 0);
         chk($sformatf("route_stall_rv%0d", s), {R0_RVALID, R1_RVALID}, 2'b01);
         chk($sformatf("route_stall_last%0d", s), R_LAST, 0);
         @(negedge ACLK);
      end
      R1_RREADY = 1'b1;
      for (int i = 0; i < 200 && done_cnt < 3; i++) @(negedge ACLK);
      chk("route_beats", rx_q.size() - base, 48);
      for (int i = 0; i < 48; i++) begin
         obs33 = (base + i < rx_q.size()) ? rx_q[base + i] : 33'bx;
         chk($sformatf("route_beat%0d", i), obs33,
             {((i / 16) == 1) ? 1'b1 : 1'b0, 16'(i / 16), 16'(i % 16)});
      end
      chk("route_outs0", OUTS_CNT, 0);
      allow_lim = 0;
      rst_pulse();

      // Outstanding limit.
      R0_RREADY     = 1'b1;
      R0_ADDR       = 32'h0000_4000;
      M_AXI_ARREADY = 1'b1;
      R0_REQ        = 1'b1;
      for (int i = 0; i < 50 && OUTS_CNT != 4; i++) @(negedge ACLK);
      chk("lim_outs4", OUTS_CNT, 4);
      for (int i = 0; i < 5; i++) begin
         @(negedge ACLK);
         chk($sformatf("lim_arv_held%0d", i), M_AXI_ARVALID, 0);
      end
      allow_lim = 1;
      for (int i = 0; i < 100 && done_cnt < 1; i++) @(negedge ACLK);
      chk("lim_outs3", OUTS_CNT, 3);
      chk("lim_arv_idle", M_AXI_ARVALID, 0);
      @(negedge ACLK);
      chk("lim_arv_reissue", M_AXI_ARVALID, 1);
      chk("lim_ack_reissue", R0_ACK, 1);
      @(negedge ACLK);
      R0_REQ = 1'b0;
      chk("lim_outs4_again", OUTS_CNT, 4);
      allow_lim = 0;
      rst_pulse();

      // Async reset during ISSUE with 2 bursts outstanding.
      M_AXI_ARREADY = 1'b1;
      issue_one(0, 32'h0000_5000, "rst_iss_a");
      issue_one(0, 32'h0000_5040, "rst_iss_b");
      chk("rst_outs2", OUTS_CNT, 2);
      M_AXI_ARREADY = 1'b0;
      R0_ADDR       = 32'h0000_5080;
      R0_REQ        = 1'b1;
      @(negedge ACLK);
      chk("rst_in_issue", M_AXI_ARVALID, 1);
      #2;
      ARESETN = 1'b0;
      #1;
      chk("arst_arvalid", M_AXI_ARVALID, 0);
      chk("arst_outs", OUTS_CNT, 0);
      chk("arst_araddr", M_AXI_ARADDR, 0);
      R0_REQ = 1'b0;
      @(negedge ACLK);
      @(negedge ACLK);
      ARESETN       = 1'b1;
      M_AXI_ARREADY = 1'b1;
      issue_one(0, 32'h0000_6000, "post_rst_iss");
      chk("post_rst_outs", OUTS_CNT, 1);
      rst_pulse();

      // Orphan beat with nothing outstanding.
      force_rv = 1'b1;
      #1;
      chk("orphan_rready", M_AXI_RREADY, 0);
      chk("orphan_rvalid", {R0_RVALID, R1_RVALID}, 0);
      chk("orphan_err_pre", R_ERR, 0);
      @(negedge ACLK);
      chk("orphan_err_set", R_ERR, 1);
      force_rv = 1'b0;
      repeat (3) @(negedge ACLK);
      chk("orphan_err_sticky", R_ERR, 1);
      ARESETN = 1'b0;
      #1;
      chk("orphan_err_rst", R_ERR, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/disp_rd_arbiter.md
# disp_rd_arbiter

Shares the single AXI4 read-address/read-data channel of the display top level between two burst requesters. Requester 0 is the frame-buffer fetch and has priority; requester 1 is a secondary fetch engine, such as an overlay or cursor. The block arbitrates AR issue, bounds the outstanding bursts, and steers R beats back to the owner in issue order. ARLEN/ARSIZE/ARBURST stay tied off at top level; every burst is 16 beats of 64 bits.

## Interface
- C_M_AXI_ADDR_WIDTH, 32, AR address width
- C_M_AXI_DATA_WIDTH, 64, R data width
- MAX_OUTS, 4, maximum bursts issued but not yet completed (RLAST); power of two, 2..8
- STARVE_LIMIT, 4, maximum consecutive requester-0 grants while requester 1 waits
- ACLK  in  1  clock; everything is rising-edge, single clock domain
- ARESETN  in  1  asynchronous, active-low reset
- R0_REQ, R1_REQ  in  1  level burst request
- R0_ADDR, R1_ADDR  in  C_M_AXI_ADDR_WIDTH  burst start address, stable while REQ is high and ACK has not yet pulsed
- R0_ACK, R1_ACK  out  1  AR handshake done for this requester (one cycle)
- R0_RVALID, R1_RVALID  out  1  beat valid for this requester
- R0_RREADY, R1_RREADY  in  1  requester accepts beat
- R_LAST  out  1  = M_AXI_RLAST
- R_DATA  out  C_M_AXI_DATA_WIDTH  = M_AXI_RDATA, shared by both requesters
- M_AXI_ARVALID  out  1
- M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH
- M_AXI_ARREADY  in  1
- M_AXI_RVALID, M_AXI_RLAST  in  1
- M_AXI_RDATA  in  C_M_AXI_DATA_WIDTH
- M_AXI_RREADY  out  1
- OUTS_CNT  out  $clog2(MAX_OUTS)+1  outstanding burst count
- R_ERR  out  1  sticky: R beat arrived with no burst outstanding

## Operation
- AR state machine has two states: IDLE and ISSUE.
- IDLE → ISSUE when (R0_REQ | R1_REQ) and OUTS_CNT < MAX_OUTS.
  - At that edge, latch the owner and the owner's address into M_AXI_ARADDR, and set ARVALID.
- Grant rule:
  - Requester 1 wins if R1_REQ and (!R0_REQ or starve_cnt == STARVE_LIMIT).
  - Otherwise requester 0 wins.
- starve_cnt:
  - Increments, saturating, on each grant to requester 0 while R1_REQ is high.
  - Clears on a grant to requester 1.
  - Clears on a grant to requester 0 while R1_REQ is low.
- ISSUE: ARVALID and ARADDR are held until ARREADY. Then:
  - Rk_ACK = ARVALID & ARREADY & owner==k, combinational.
  - The owner id is pushed into the owner FIFO.
  - ARVALID clears.
  - The state returns to IDLE.
- Requesters drop REQ or present a new address on the edge following ACK. IDLE samples the updated REQ, so a stale request is never re-granted.
- R routing uses the owner FIFO head h:
  - Rk_RVALID = M_AXI_RVALID & !empty & h==k.
  - M_AXI_RREADY = !empty & Rh_RREADY.
- FIFO pop on M_AXI_RVALID & M_AXI_RREADY & M_AXI_RLAST.
- Push and pop in the same cycle leave OUTS_CNT unchanged. Push is never attempted when full, because IDLE checks the count.
- M_AXI_RVALID while FIFO empty:
  - RREADY stays 0 and no Rk_RVALID is raised.
  - R_ERR sets and holds until reset.

## Timing
- Reset, asynchronous, immediate:
  - ARVALID=0, ARADDR=0, ACKs=0, Rk_RVALID=0, M_AXI_RREADY=0, OUTS_CNT=0, R_ERR=0.
  - State IDLE, starve_cnt=0, FIFO empty.
- Reset mid-burst discards all ownership. The interconnect shares ARESETN.
- Request to ARVALID: 1 cycle, since REQ is sampled in IDLE and ARVALID is registered.
- Minimum AR spacing: 2 cycles (ISSUE with ARREADY=1, then IDLE).
- R path: zero latency, purely combinational from FIFO head and AXI inputs. The owner change takes effect the cycle after the RLAST beat.
- Burst N+1 data may follow burst N RLAST back to back. The FIFO head updates at that edge.

## Structure
- Package disp_axi_pkg:
  - owner_t (OWN_DISP=0, OWN_AUX=1).
  - arb_state_t (IDLE, ISSUE).
  - BURST_BEATS=16 and the ARSIZE/ARBURST constants shared with the top level.
- Sub-module disp_owner_fifo: synchronous FIFO, width 1, depth MAX_OUTS, with push/pop/empty/full/count. It carries its own asynchronous active-low reset.
- Arbiter, starve counter and R steering stay in disp_rd_arbiter.

## Test plan
- Both REQ held high, ARREADY=1, R returned promptly → grant order 0,0,0,0,1,0,0,0,0,1 with STARVE_LIMIT=4. Each ACK is one cycle.
- R0_REQ only, ARREADY held 0 for 5 cycles → ARVALID high 5+ cycles with ARADDR=R0_ADDR constant. R0_ACK pulses in the ARREADY cycle only.
- Issue 4 bursts with no R data → OUTS_CNT=4 and ARVALID stays 0 despite REQ. After one 16-beat burst completes with RLAST, OUTS_CNT=3 and the next AR issues within 2 cycles.
- Interleaved owners 0,1,0, slave returns three 16-beat bursts back to back → beats 0-15 to R0, 16-31 to R1, 32-47 to R0. R1_RREADY=0 for 3 cycles stalls M_AXI_RREADY only during burst 2.
- M_AXI_RVALID=1 with FIFO empty → M_AXI_RREADY=0, both Rk_RVALID=0, R_ERR=1 and stays 1.
- ARESETN low during ISSUE with 2 bursts outstanding → ARVALID=0 and OUTS_CNT=0 without a clock edge. After release, the first REQ issues normally.
